// File: rtl/adam_dmi_pkg.sv
// Shared constants for the DMI system-bus-access sequencer: DM register map,
// SBCS field positions and the two SBCS configuration words.
package adam_dmi_pkg;

  typedef logic [6:0]  dmaddr_t;
  typedef logic [31:0] dmdata_t;

  localparam dmaddr_t A_SBCS       = 7'h38;
  localparam dmaddr_t A_SBADDRESS0 = 7'h39;
  localparam dmaddr_t A_SBDATA0    = 7'h3C;

  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  // SBCS field positions; sbaccess occupies 19:17 and sberror 14:12
  localparam int SBBUSYERROR  = 22;
  localparam int SBBUSY       = 21;
  localparam int SBREADONADDR = 20;
  localparam int SBACCESS_LO  = 17;
  localparam int SBERROR_HI   = 14;
  localparam int SBERROR_LO   = 12;

  localparam logic [2:0] SBACCESS_32 = 3'd2;

  // 32-bit access with W1C of sbbusyerror and sberror; reads also set sbreadonaddr
  localparam dmdata_t SBCS_CFG_WR = (32'd1 << SBBUSYERROR) |
                                    (32'(SBACCESS_32) << SBACCESS_LO) |
                                    (32'd7 << SBERROR_LO);
  localparam dmdata_t SBCS_CFG_RD = SBCS_CFG_WR | (32'd1 << SBREADONADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL0, S_CFG, S_ADDR, S_DATA, S_POLL1, S_RDDATA, S_RSP
  } seq_state_e;

  typedef enum logic [1:0] {X_IDLE, X_ISSUE, X_WAIT} xfer_state_e;

  function automatic logic sbcs_err(input dmdata_t sbcs);
    return sbcs[SBBUSYERROR] | (|sbcs[SBERROR_HI:SBERROR_LO]);
  endfunction

endpackage

// File: rtl/adam_dmi_xfer.sv
// Runs a single DMI operation: holds the request stable until accepted, then
// waits for the response and reports done/fail/data for one cycle.
module adam_dmi_xfer
  import adam_dmi_pkg::*;
#(
  parameter int ABITS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ABITS-1:0] addr_i,
  input  logic [1:0]       op_i,
  input  dmdata_t          data_i,
  output logic             done_o,
  output logic             fail_o,
  output dmdata_t          rdata_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [1:0]       dmi_req_op_o,
  output logic [31:0]      dmi_req_data_o,
  input  logic             dmi_rsp_valid_i,
  output logic             dmi_rsp_ready_o,
  input  logic [31:0]      dmi_rsp_data_i,
  input  logic [1:0]       dmi_rsp_resp_i
);

  xfer_state_e      state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [1:0]       op_q, op_d;
  dmdata_t          data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= X_IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      X_IDLE: begin
        if (start_i) begin
          addr_d  = addr_i;
          op_d    = op_i;
          data_d  = data_i;
          state_d = X_ISSUE;
        end
      end
      X_ISSUE: if (dmi_req_ready_i) state_d = X_WAIT;
      X_WAIT:  if (dmi_rsp_valid_i) state_d = X_IDLE;
      default: state_d = X_IDLE;
    endcase
  end

  // Handshakes are masked during reset so nothing is accepted on the reset edge
  assign dmi_req_valid_o = (state_q == X_ISSUE) & ~rst;
  assign dmi_rsp_ready_o = (state_q == X_WAIT) & ~rst;
  assign dmi_req_addr_o  = addr_q;
  assign dmi_req_op_o    = op_q;
  assign dmi_req_data_o  = data_q;

  assign done_o  = dmi_rsp_ready_o & dmi_rsp_valid_i;
  assign fail_o  = dmi_rsp_resp_i != 2'd0;
  assign rdata_o = dmi_rsp_data_i;

endmodule

// File: rtl/adam_dmi_sba_seq.sv
// Turns single 32-bit memory requests into SBA register sequences on the debug
// module: poll sbbusy, program SBCS/SBADDRESS0/SBDATA0, and report sberror.
module adam_dmi_sba_seq
  import adam_dmi_pkg::*;
#(
  parameter int ABITS      = 7,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_POLL   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [ABITS-1:0]      dmi_req_addr_o,
  output logic [1:0]            dmi_req_op_o,
  output logic [31:0]           dmi_req_data_o,
  input  logic                  dmi_rsp_valid_i,
  output logic                  dmi_rsp_ready_o,
  input  logic [31:0]           dmi_rsp_data_i,
  input  logic [1:0]            dmi_rsp_resp_i
);

  localparam int CW = $clog2(MAX_POLL + 1);

  seq_state_e            state_q, state_d;
  logic                  issued_q, issued_d;
  logic [CW-1:0]         pollCnt_q, pollCnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic    xferStart, xferDone, xferFail;
  dmaddr_t xferAddr;
  logic [1:0] xferOp;
  dmdata_t xferData, xferRdata;

  adam_dmi_xfer #(.ABITS(ABITS)) u_xfer (
    .clk             (clk),
    .rst             (rst),
    .start_i         (xferStart),
    .addr_i          (ABITS'(xferAddr)),
    .op_i            (xferOp),
    .data_i          (xferData),
    .done_o          (xferDone),
    .fail_o          (xferFail),
    .rdata_o         (xferRdata),
    .dmi_req_valid_o (dmi_req_valid_o),
    .dmi_req_ready_i (dmi_req_ready_i),
    .dmi_req_addr_o  (dmi_req_addr_o),
    .dmi_req_op_o    (dmi_req_op_o),
    .dmi_req_data_o  (dmi_req_data_o),
    .dmi_rsp_valid_i (dmi_rsp_valid_i),
    .dmi_rsp_ready_o (dmi_rsp_ready_o),
    .dmi_rsp_data_i  (dmi_rsp_data_i),
    .dmi_rsp_resp_i  (dmi_rsp_resp_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      issued_q  <= 1'b0;
      pollCnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      pollCnt_q <= pollCnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    pollCnt_d = pollCnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    xferStart = 1'b0;
    xferAddr  = A_SBCS;
    xferOp    = DMI_OP_READ;
    xferData  = '0;

    case (state_q)
      S_CFG: begin
        xferOp   = DMI_OP_WRITE;
        xferData = we_q ? SBCS_CFG_WR : SBCS_CFG_RD;
      end
      S_ADDR: begin
        xferAddr = A_SBADDRESS0;
        xferOp   = DMI_OP_WRITE;
        xferData = dmdata_t'(addr_q);
      end
      S_DATA: begin
        xferAddr = A_SBDATA0;
        xferOp   = DMI_OP_WRITE;
        xferData = dmdata_t'(wdata_q);
      end
      S_RDDATA: xferAddr = A_SBDATA0;
      default: ;
    endcase

    // Each phase launches exactly one DMI op and waits for it before moving on
    if (state_q != S_IDLE && state_q != S_RSP && !issued_q) begin
      xferStart = 1'b1;
      issued_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d      = req_we_i;
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          rdata_d   = '0;
          err_d     = 1'b0;
          pollCnt_d = '0;
          state_d   = S_POLL0;
        end
      end
      S_RSP: if (rsp_ready_i) state_d = S_IDLE;
      default: begin
        if (xferDone) begin
          issued_d = 1'b0;
          if (xferFail) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RSP;
          end else begin
            case (state_q)
              S_POLL0, S_POLL1: begin
                if (xferRdata[SBBUSY]) begin
                  if (pollCnt_q >= CW'(MAX_POLL - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RSP;
                  end else if (pollCnt_q != '1) begin
                    pollCnt_d = pollCnt_q + 1'b1;
                  end
                end else begin
                  pollCnt_d = '0;
                  if (state_q == S_POLL0) begin
                    state_d = S_CFG;
                  end else if (sbcs_err(xferRdata)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RSP;
                  end else begin
                    state_d = we_q ? S_RSP : S_RDDATA;
                  end
                end
              end
              S_CFG:  state_d = S_ADDR;
              S_ADDR: state_d = we_q ? S_DATA : S_POLL1;
              S_DATA: state_d = S_POLL1;
              S_RDDATA: begin
                rdata_d = DATA_WIDTH'(xferRdata);
                state_d = S_RSP;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
